// File: rtl/ula_sequencer.sv
// rtl/ula_sequencer.sv - multi-cycle sequencer for the register-file / SrcB-mux / ULA datapath
//
// Accepts one operation per valid/ready handshake and steps it through EXEC/WRITE
// pairs, repeating (count+1) times with rs1 re-pointed to rd after the first pass.
// Can stop early when the ULA Zero flag is seen, or be cancelled with i_abort.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   i_valid / o_ready       request handshake, o_ready only in IDLE
//   i_ula_control, i_alu_src, i_rd, i_rs1, i_rs2, i_imm, i_count, i_stop_on_zero
//                           operation fields, latched on accept
//   i_abort                 cancel (honoured in EXEC, deferred to end of WRITE)
//   i_zero                  ULA Zero flag from datapath
//   o_rf_addr1/2, o_rf_waddr, o_rf_we   register-file control
//   o_alu_src, o_imm, o_ula_control     SrcB mux and ULA control
//   o_busy, o_done, o_zero_flag, o_iters  status

module ula_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_ula_control,
  input  logic              i_alu_src,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_stop_on_zero,
  input  logic              i_abort,
  input  logic              i_zero,
  output logic [ADDR_W-1:0] o_rf_addr1,
  output logic [ADDR_W-1:0] o_rf_addr2,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic              o_rf_we,
  output logic              o_alu_src,
  output logic [DATA_W-1:0] o_imm,
  output logic [2:0]        o_ula_control,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_zero_flag,
  output logic [CNT_W:0]    o_iters
);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE, DONE} state_t;

  state_t              state_q;

  // Latched operation fields that are not directly mirrored on an output.
  logic [ADDR_W-1:0]   rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                stop_q;

  logic [ADDR_W-1:0]   rf_addr1_q;
  logic [ADDR_W-1:0]   rf_addr2_q;
  logic [ADDR_W-1:0]   rf_waddr_q;
  logic                rf_we_q;
  logic                alu_src_q;
  logic [DATA_W-1:0]   imm_q;
  logic [2:0]          ula_q;
  logic                done_q;
  logic                zero_q;
  logic [CNT_W:0]      iters_q;

  // The write completing now is the last one when iters_q (writes already done)
  // equals count, i.e. this write brings the total to count+1.
  logic                last_iter;
  logic [CNT_W:0]      iters_inc;

  assign last_iter = (iters_q == {1'b0, cnt_q});
  assign iters_inc = iters_q + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      rf_addr1_q <= '0;
      rf_addr2_q <= '0;
      rf_waddr_q <= '0;
      rf_we_q    <= 1'b0;
      alu_src_q  <= 1'b0;
      imm_q      <= '0;
      ula_q      <= '0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      iters_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            rd_q       <= i_rd;
            cnt_q      <= i_count;
            stop_q     <= i_stop_on_zero;
            rf_addr1_q <= i_rs1;
            rf_addr2_q <= i_rs2;
            rf_waddr_q <= '0;
            rf_we_q    <= 1'b0;
            alu_src_q  <= i_alu_src;
            imm_q      <= i_imm;
            ula_q      <= i_ula_control;
            zero_q     <= 1'b0;
            iters_q    <= '0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          zero_q <= i_zero;
          if (i_abort) begin
            done_q     <= 1'b1;
            rf_addr1_q <= '0;
            rf_addr2_q <= '0;
            rf_waddr_q <= '0;
            rf_we_q    <= 1'b0;
            alu_src_q  <= 1'b0;
            imm_q      <= '0;
            ula_q      <= '0;
            state_q    <= DONE;
          end else begin
            // Read addresses and ULA control stay put; only the write strobe rises.
            rf_we_q    <= 1'b1;
            rf_waddr_q <= rd_q;
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          iters_q    <= iters_inc;
          rf_we_q    <= 1'b0;
          rf_waddr_q <= '0;
          // zero_q already holds the Zero sampled at the end of the preceding EXEC.
          if (last_iter || (stop_q && zero_q) || i_abort) begin
            done_q     <= 1'b1;
            rf_addr1_q <= '0;
            rf_addr2_q <= '0;
            alu_src_q  <= 1'b0;
            imm_q      <= '0;
            ula_q      <= '0;
            state_q    <= DONE;
          end else begin
            // Accumulate: later iterations read the destination as the first source.
            rf_addr1_q <= rd_q;
            state_q    <= EXEC;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready       = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_rf_addr1    = rf_addr1_q;
  assign o_rf_addr2    = rf_addr2_q;
  assign o_rf_waddr    = rf_waddr_q;
  assign o_rf_we       = rf_we_q;
  assign o_alu_src     = alu_src_q;
  assign o_imm         = imm_q;
  assign o_ula_control = ula_q;
  assign o_done        = done_q;
  assign o_zero_flag   = zero_q;
  assign o_iters       = iters_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// tb/tb_ula_sequencer.sv - directed self-checking bench for ula_sequencer

module tb_ula_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_ula_control;
  logic              i_alu_src;
  logic [ADDR_W-1:0] i_rd;
  logic [ADDR_W-1:0] i_rs1;
  logic [ADDR_W-1:0] i_rs2;
  logic [DATA_W-1:0] i_imm;
  logic [CNT_W-1:0]  i_count;
  logic              i_stop_on_zero;
  logic              i_abort;
  logic              i_zero;
  logic [ADDR_W-1:0] o_rf_addr1;
  logic [ADDR_W-1:0] o_rf_addr2;
  logic [ADDR_W-1:0] o_rf_waddr;
  logic              o_rf_we;
  logic              o_alu_src;
  logic [DATA_W-1:0] o_imm;
  logic [2:0]        o_ula_control;
  logic              o_busy;
  logic              o_done;
  logic              o_zero_flag;
  logic [CNT_W:0]    o_iters;

  always #5 clock = ~clock;

  ula_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_ula_control(i_ula_control), .i_alu_src(i_alu_src), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_count(i_count),
    .i_stop_on_zero(i_stop_on_zero), .i_abort(i_abort), .i_zero(i_zero),
    .o_rf_addr1(o_rf_addr1), .o_rf_addr2(o_rf_addr2), .o_rf_waddr(o_rf_waddr),
    .o_rf_we(o_rf_we), .o_alu_src(o_alu_src), .o_imm(o_imm),
    .o_ula_control(o_ula_control), .o_busy(o_busy), .o_done(o_done),
    .o_zero_flag(o_zero_flag), .o_iters(o_iters)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0]       we_mask;
  int                done_cyc;
  logic [ADDR_W-1:0] a1_log [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [2:0] ctl, input logic src, input logic [ADDR_W-1:0] rd,
                        input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                        input logic [DATA_W-1:0] imm, input logic [CNT_W-1:0] cnt,
                        input logic stop);
    i_ula_control  = ctl;
    i_alu_src      = src;
    i_rd           = rd;
    i_rs1          = rs1;
    i_rs2          = rs2;
    i_imm          = imm;
    i_count        = cnt;
    i_stop_on_zero = stop;
  endtask

  // Accepts the pending op, then logs each cycle (cycle 1 = first EXEC) until done.
  // i_abort / i_zero are raised only during the named cycle.
  task automatic run_op(input int abort_cyc, input int zero_cyc);
    we_mask  = '0;
    done_cyc = -1;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    for (int c = 1; c < 48; c++) begin
      i_abort    = (c == abort_cyc);
      i_zero     = (c == zero_cyc);
      we_mask[c] = o_rf_we;
      a1_log[c]  = o_rf_addr1;
      if (o_done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    i_abort = 1'b0;
    i_zero  = 1'b0;
    if (done_cyc < 0) chk("done_timeout", {31'd0, o_done}, 32'd1);
    tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {o_rf_addr1, o_rf_addr2, o_rf_waddr, o_rf_we, o_alu_src, o_imm,
            o_ula_control, o_done, o_zero_flag, o_iters};
  endfunction

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_abort = 1'b0;
    i_zero  = 1'b0;
    set_op(3'd0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    chk("rst_outs", all_outs(), 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    reset = 1'b0;

    // Reset mid-run, with i_valid held high: reset wins.
    set_op(3'b110, 1'b1, 3'd2, 3'd5, 3'd6, 8'hA5, 4'd3, 1'b0);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    chk("midrun_busy", {31'd0, o_busy}, 32'd1);
    reset   = 1'b1;
    i_valid = 1'b1;
    tick();
    tick();
    chk("rst2_outs", all_outs(), 32'd0);
    chk("rst2_ready", {31'd0, o_ready}, 32'd1);
    chk("rst2_busy", {31'd0, o_busy}, 32'd0);
    reset   = 1'b0;
    i_valid = 1'b0;
    tick();

    // Single add-immediate, stepped by hand.
    set_op(3'b010, 1'b1, 3'd3, 3'd1, 3'd4, 8'h07, 4'd0, 1'b0);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("add_c1_addr1", {29'd0, o_rf_addr1}, 32'd1);
    chk("add_c1_addr2", {29'd0, o_rf_addr2}, 32'd4);
    chk("add_c1_ctl", {20'd0, o_ula_control, o_alu_src, o_imm}, {20'd0, 3'b010, 1'b1, 8'h07});
    chk("add_c1_we", {31'd0, o_rf_we}, 32'd0);
    chk("add_c1_ready", {30'd0, o_ready, o_busy}, 32'b01);
    tick();
    chk("add_c2_we", {31'd0, o_rf_we}, 32'd1);
    chk("add_c2_waddr", {29'd0, o_rf_waddr}, 32'd3);
    chk("add_c2_addr1", {29'd0, o_rf_addr1}, 32'd1);
    chk("add_c2_ctl", {20'd0, o_ula_control, o_alu_src, o_imm}, {20'd0, 3'b010, 1'b1, 8'h07});
    tick();
    chk("add_c3_done", {31'd0, o_done}, 32'd1);
    chk("add_c3_iters", {27'd0, o_iters}, 32'd1);
    chk("add_c3_ctl0", {20'd0, o_ula_control, o_alu_src, o_imm}, 32'd0);
    chk("add_c3_we", {31'd0, o_rf_we}, 32'd0);
    tick();
    chk("add_c4_ready", {30'd0, o_ready, o_done}, 32'b10);

    // Repeat count=3 with accumulate.
    set_op(3'b000, 1'b0, 3'd2, 3'd5, 3'd1, 8'h00, 4'd3, 1'b0);
    run_op(-1, -1);
    chk("rep_we_mask", we_mask[31:0], 32'h0000_0154);
    chk("rep_done_cyc", done_cyc, 32'd9);
    chk("rep_iters", {27'd0, o_iters}, 32'd4);
    chk("rep_addr1", {20'd0, a1_log[1], a1_log[3], a1_log[5], a1_log[7]},
        {20'd0, 3'd5, 3'd2, 3'd2, 3'd2});

    // Stop on zero.
    set_op(3'b001, 1'b0, 3'd6, 3'd6, 3'd6, 8'h00, 4'd5, 1'b1);
    run_op(-1, 1);
    chk("soz_we_mask", we_mask[31:0], 32'h0000_0004);
    chk("soz_done_cyc", done_cyc, 32'd3);
    chk("soz_zero", {31'd0, o_zero_flag}, 32'd1);
    chk("soz_iters", {27'd0, o_iters}, 32'd1);

    // Same with stop disabled: all six iterations run, last Zero sample was 0.
    set_op(3'b001, 1'b0, 3'd6, 3'd6, 3'd6, 8'h00, 4'd5, 1'b0);
    run_op(-1, 1);
    chk("nsz_we_mask", we_mask[31:0], 32'h0000_1554);
    chk("nsz_done_cyc", done_cyc, 32'd13);
    chk("nsz_iters", {27'd0, o_iters}, 32'd6);
    chk("nsz_zero", {31'd0, o_zero_flag}, 32'd0);

    // Abort in first EXEC: no write at all.
    set_op(3'b011, 1'b1, 3'd1, 3'd2, 3'd3, 8'h33, 4'd0, 1'b0);
    run_op(1, -1);
    chk("abx_we_mask", we_mask[31:0], 32'd0);
    chk("abx_done_cyc", done_cyc, 32'd2);
    chk("abx_iters", {27'd0, o_iters}, 32'd0);

    // Abort in WRITE of a count=3 op: that write still happens.
    set_op(3'b011, 1'b1, 3'd1, 3'd2, 3'd3, 8'h33, 4'd3, 1'b0);
    run_op(2, -1);
    chk("abw_we_mask", we_mask[31:0], 32'h0000_0004);
    chk("abw_done_cyc", done_cyc, 32'd3);
    chk("abw_iters", {27'd0, o_iters}, 32'd1);

    // Maximum count: 16 iterations, iters reaches 16 without wrapping.
    set_op(3'b100, 1'b0, 3'd7, 3'd0, 3'd7, 8'h01, 4'd15, 1'b0);
    run_op(-1, -1);
    chk("max_done_cyc", done_cyc, 32'd33);
    chk("max_iters", {27'd0, o_iters}, 32'd16);

    // i_valid held through an op; fields changed mid-op are only taken at next accept.
    set_op(3'b001, 1'b0, 3'd4, 3'd3, 3'd2, 8'h11, 4'd0, 1'b0);
    i_valid = 1'b1;
    tick();
    chk("hold_c1_addr1", {29'd0, o_rf_addr1}, 32'd3);
    set_op(3'b101, 1'b1, 3'd6, 3'd7, 3'd1, 8'h5A, 4'd0, 1'b0);
    tick();
    chk("hold_c2_waddr", {28'd0, o_rf_we, o_rf_waddr}, {28'd0, 1'b1, 3'd4});
    chk("hold_c2_ctl", {20'd0, o_ula_control, o_alu_src, o_imm}, {20'd0, 3'b001, 1'b0, 8'h11});
    tick();
    chk("hold_c3_done", {30'd0, o_done, o_ready}, 32'b10);
    tick();
    chk("hold_c4_idle", {30'd0, o_ready, o_busy}, 32'b10);
    tick();
    chk("hold_c5_busy", {31'd0, o_busy}, 32'd1);
    chk("hold_c5_addr", {26'd0, o_rf_addr1, o_rf_addr2}, {26'd0, 3'd7, 3'd1});
    chk("hold_c5_ctl", {20'd0, o_ula_control, o_alu_src, o_imm}, {20'd0, 3'b101, 1'b1, 8'h5A});
    tick();
    chk("hold_c6_waddr", {28'd0, o_rf_we, o_rf_waddr}, {28'd0, 1'b1, 3'd6});
    i_valid = 1'b0;
    tick();
    chk("hold_c7_done", {31'd0, o_done}, 32'd1);
    tick();
    tick();
    chk("hold_idle", {30'd0, o_ready, o_busy}, 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
